// File: rtl/pdm_pkg.sv
// Shared command encodings, run states, sample/word geometry and the
// ones-count to PCM conversion used by the PDM capture front end.
package pdm_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_START = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;
    localparam int CH0_LSB  = 0;
    localparam int CH1_LSB  = 16;

    // Boxcar result: 2*ones - decim, wrapping to a two's complement sample
    function automatic logic [SAMPLE_W-1:0] ones_to_pcm(
        input logic [SAMPLE_W-1:0] ones,
        input logic [SAMPLE_W-1:0] decim
    );
        return {ones[SAMPLE_W-2:0], 1'b0} - decim;
    endfunction

endpackage

// File: rtl/pdm_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; the head word reads
// as zero while empty so reset and flush blank the output immediately.
module pdm_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO still takes a push when the head is popped in the same cycle
    always_comb begin
        empty     = (count_r == {(AW + 1){1'b0}});
        full      = (count_r == COUNT_FULL);
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
        level     = count_r;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (push_ok_s && !pop_ok_s)      count_r <= count_r + COUNT_ONE;
            else if (!push_ok_s && pop_ok_s) count_r <= count_r - COUNT_ONE;
        end
    end

    // Storage array; contents are only visible through the masked head word
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/pdm_capture_mc.sv
// Multi-channel PDM capture: PDM clock generation, dual-phase sampling,
// ones-count decimation and a FWFT output FIFO, all on AHBclk.
module pdm_capture_mc
    import pdm_pkg::*;
#(
    parameter int CLK_DIV    = 33,
    parameter int DECIM      = 64,
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          AHBclk,
    input  logic                          rst,
    input  logic [1:0]                    ctrl,
    input  logic                          pdm_data,
    output logic                          pdm_clk,
    input  logic                          pop,
    output logic [WORD_W-1:0]             dout,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          bsy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DECIM) + 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1'b1);
    localparam logic [CNT_W-1:0]    BIT_LAST = CNT_W'(DECIM - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
    localparam logic [SAMPLE_W-1:0] DECIM_W  = SAMPLE_W'(DECIM);

    state_t              state_r;
    state_t              next_state_s;
    logic                cmd_start_s, cmd_stop_s, cmd_clear_s;
    logic                run_s, active_s, tc_s, cap0_s, cap1_s, frame_done_s;
    logic [DIV_W-1:0]    div_r;
    logic                pdm_clk_r;
    logic [CNT_W-1:0]    ones0_r, ones1_r, bits0_r, bits1_r;
    logic [CNT_W-1:0]    ones0_sum_s, ones1_sum_s;
    logic [SAMPLE_W-1:0] pcm0_s, pcm1_s;
    logic [WORD_W-1:0]   word_s, word_r;
    logic                push_r, overflow_r;
    logic                fifo_full_s, fifo_empty_s;

    // Command decode, slot timing and frame assembly
    always_comb begin
        cmd_start_s = (ctrl == CMD_START);
        cmd_stop_s  = (ctrl == CMD_STOP);
        cmd_clear_s = (ctrl == CMD_CLEAR);
        run_s       = (state_r == ST_RUN);
        active_s    = run_s && !cmd_stop_s && !cmd_clear_s;
        tc_s        = run_s && (div_r == DIV_LAST);
        cap0_s      = active_s && tc_s && pdm_clk_r;
        // A ch1 slot only counts once its frame has a ch0 bit, so frames open on ch0
        cap1_s      = active_s && tc_s && !pdm_clk_r && (NCH == 2) && (bits0_r != bits1_r);
        frame_done_s = (NCH == 2) ? (cap1_s && (bits1_r == BIT_LAST))
                                  : (cap0_s && (bits0_r == BIT_LAST));
        ones0_sum_s = ones0_r + {{(CNT_W - 1){1'b0}}, pdm_data};
        ones1_sum_s = ones1_r + {{(CNT_W - 1){1'b0}}, pdm_data};
        pcm0_s = ones_to_pcm(SAMPLE_W'((NCH == 2) ? ones0_r : ones0_sum_s), DECIM_W);
        pcm1_s = ones_to_pcm(SAMPLE_W'(ones1_sum_s), DECIM_W);
        word_s = {WORD_W{1'b0}};
        word_s[CH0_LSB +: SAMPLE_W] = pcm0_s;
        word_s[CH1_LSB +: SAMPLE_W] = (NCH == 2) ? pcm1_s : {SAMPLE_W{pcm0_s[SAMPLE_W-1]}};
    end

    // Next run state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_start_s) next_state_s = ST_RUN;
                else             next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cmd_stop_s) next_state_s = ST_IDLE;
                else            next_state_s = ST_RUN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Run-state register
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Divider and PDM clock; held low outside RUN and restarted by stop or clear
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) begin
            div_r     <= {DIV_W{1'b0}};
            pdm_clk_r <= 1'b0;
        end else if (!active_s) begin
            div_r     <= {DIV_W{1'b0}};
            pdm_clk_r <= 1'b0;
        end else if (tc_s) begin
            div_r     <= {DIV_W{1'b0}};
            pdm_clk_r <= !pdm_clk_r;
        end else begin
            div_r     <= div_r + DIV_ONE;
        end
    end

    // Per-channel ones and bit counters, zeroed between frames
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) begin
            ones0_r <= {CNT_W{1'b0}};
            ones1_r <= {CNT_W{1'b0}};
            bits0_r <= {CNT_W{1'b0}};
            bits1_r <= {CNT_W{1'b0}};
        end else if (!active_s || frame_done_s) begin
            ones0_r <= {CNT_W{1'b0}};
            ones1_r <= {CNT_W{1'b0}};
            bits0_r <= {CNT_W{1'b0}};
            bits1_r <= {CNT_W{1'b0}};
        end else begin
            if (cap0_s) begin
                ones0_r <= ones0_sum_s;
                bits0_r <= bits0_r + CNT_ONE;
            end
            if (cap1_s) begin
                ones1_r <= ones1_sum_s;
                bits1_r <= bits1_r + CNT_ONE;
            end
        end
    end

    // Completed word is presented to the FIFO the cycle after the last capture
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) begin
            push_r <= 1'b0;
            word_r <= {WORD_W{1'b0}};
        end else begin
            push_r <= frame_done_s;
            if (frame_done_s) word_r <= word_s;
        end
    end

    // Sticky drop flag
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst)                                    overflow_r <= 1'b0;
        else if (cmd_clear_s)                        overflow_r <= 1'b0;
        else if (push_r && fifo_full_s && !pop)      overflow_r <= 1'b1;
    end

    pdm_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (AHBclk),
        .rst_n (rst),
        .flush (cmd_clear_s),
        .push  (push_r),
        .wdata (word_r),
        .pop   (pop),
        .rdata (dout),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    assign valid    = !fifo_empty_s;
    assign pdm_clk  = pdm_clk_r;
    assign overflow = overflow_r;
    assign bsy      = (state_r == ST_RUN);

endmodule

// File: tb/tb_pdm_capture_mc.sv
// Randomised bench for pdm_capture_mc against a slot/queue model of the capture front end.
module tb_pdm_capture_mc;

    localparam int CLK_DIV    = 2;
    localparam int DECIM      = 8;
    localparam int NCH        = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    logic          AHBclk = 1'b0;
    logic          rst;
    logic [1:0]    ctrl;
    logic          pdm_data;
    logic          pdm_clk;
    logic          pop;
    logic [31:0]   dout;
    logic          valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic          bsy;

    pdm_capture_mc #(
        .CLK_DIV    (CLK_DIV),
        .DECIM      (DECIM),
        .NCH        (NCH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .AHBclk   (AHBclk),
        .rst      (rst),
        .ctrl     (ctrl),
        .pdm_data (pdm_data),
        .pdm_clk  (pdm_clk),
        .pop      (pop),
        .dout     (dout),
        .valid    (valid),
        .level    (level),
        .overflow (overflow),
        .bsy      (bsy)
    );

    always #5 AHBclk = ~AHBclk;

    int checks = 0;
    int passes = 0;

    // Model: time since start, bits of the frame in progress, output queue
    bit          chk_en = 1'b0;
    bit          m_run;
    bit          m_ovf;
    bit          m_pend;
    int          m_t;
    logic [31:0] m_pend_word;
    bit          fb[$];
    logic [31:0] mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic exp_clk();
        return m_run && (((m_t / CLK_DIV) % 2) == 1);
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_ovf = 1'b0; m_pend = 1'b0; m_t = 0;
        m_pend_word = 32'h0;
        fb.delete();
        mq.delete();
    endtask

    // One clock of the model, using the inputs applied during that cycle
    task automatic model_step(input logic [1:0] c, input logic d, input logic p);
        bit          popped;
        bit          new_pend;
        logic [31:0] new_word;
        int          o0, o1;
        new_pend = 1'b0;
        new_word = 32'h0;
        if (c == CLEAR) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            popped = p && (mq.size() > 0);
            if (popped) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(m_pend_word);
                else m_ovf = 1'b1;
            end
        end
        // Slot n ends at time n*CLK_DIV+CLK_DIV-1; slot 0 is skipped, odd slots are ch0
        if (m_run && c != STOP && c != CLEAR && (m_t % CLK_DIV) == CLK_DIV - 1
            && (m_t / CLK_DIV) >= 1) begin
            fb.push_back(d);
            if (fb.size() == 2 * DECIM) begin
                o0 = 0; o1 = 0;
                foreach (fb[i]) begin
                    if (i % 2 == 0) o0 += int'(fb[i]);
                    else            o1 += int'(fb[i]);
                end
                new_word = {16'(2 * o1 - DECIM), 16'(2 * o0 - DECIM)};
                new_pend = 1'b1;
                fb.delete();
            end
        end
        if (!m_run) begin
            if (c == START) begin m_run = 1'b1; m_t = 0; fb.delete(); end
        end else if (c == STOP) begin
            m_run = 1'b0; m_t = 0; fb.delete();
        end else if (c == CLEAR) begin
            m_t = 0; fb.delete();
        end else begin
            m_t++;
        end
        m_pend      = new_pend;
        m_pend_word = new_word;
    endtask

    // Every-cycle comparison against the model
    always @(negedge AHBclk) begin
        if (chk_en) begin
            chk("pdm_clk",  32'(pdm_clk),  32'(exp_clk()));
            chk("bsy",      32'(bsy),      32'(m_run));
            chk("valid",    32'(valid),    32'(mq.size() > 0));
            chk("level",    32'(level),    32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("dout",     dout,          (mq.size() > 0) ? mq[0] : 32'h0);
        end
    end

    task automatic cycle(input logic [1:0] c, input logic d, input logic p);
        ctrl = c; pdm_data = d; pop = p;
        @(posedge AHBclk);
        model_step(c, d, p);
        @(negedge AHBclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int got;
        int rises[$];
        logic prev;
        int r;
        logic [1:0] c;

        rst = 1'b0; ctrl = NOP; pdm_data = 1'b0; pop = 1'b0;
        model_reset();
        repeat (3) @(negedge AHBclk);
        rst = 1'b1;
        chk_en = 1'b1;

        // 1: idle after reset
        repeat (100) cycle(NOP, 1'($urandom()), 1'b0);
        chk("t1_pdm_clk",  32'(pdm_clk),  32'd0);
        chk("t1_dout",     dout,          32'h0);
        chk("t1_valid",    32'(valid),    32'd0);
        chk("t1_level",    32'(level),    32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_bsy",      32'(bsy),      32'd0);

        // 2: all-ones data, clock period and first-word latency
        cycle(START, 1'b1, 1'b0);
        cyc = 0;
        while (!valid && cyc < 200) begin
            prev = pdm_clk;
            cycle(NOP, 1'b1, 1'b0);
            cyc++;
            if (pdm_clk && !prev) rises.push_back(cyc);
        end
        chk("t2_valid_latency", 32'(cyc), 32'd35);
        chk("t2_first_rise", (rises.size() > 0) ? 32'(rises[0]) : 32'hFFFFFFFF, 32'd2);
        chk("t2_clk_period", (rises.size() > 1) ? 32'(rises[1] - rises[0]) : 32'hFFFFFFFF, 32'd4);
        chk("t2_first_word", dout, 32'h00080008);

        // 3: ones on ch0 slots, zeros on ch1 slots
        cycle(CLEAR, 1'b0, 1'b0);
        got = 0;
        for (int i = 0; i < 300 && got < 3; i++) begin
            if (valid) begin
                chk("t3_word", dout, 32'hFFF80008);
                got++;
            end
            cycle(NOP, pdm_clk, valid);
        end
        chk("t3_words", 32'(got), 32'd3);

        // 4: 17 frames with no pops, then drain and clear
        cycle(CLEAR, 1'b0, 1'b0);
        repeat (560) cycle(NOP, 1'($urandom()), 1'b0);
        cycle(STOP, 1'b0, 1'b0);
        chk("t4_level_full", 32'(level),    32'd16);
        chk("t4_overflow",   32'(overflow), 32'd1);
        repeat (16) cycle(NOP, 1'b0, 1'b1);
        chk("t4_drained_valid", 32'(valid), 32'd0);
        cycle(CLEAR, 1'b0, 1'b0);
        chk("t4_overflow_cleared", 32'(overflow), 32'd0);

        // 5: stop after the 5th bit of a zero frame, restart with ones
        cycle(START, 1'b1, 1'b0);
        repeat (34) cycle(NOP, 1'b1, 1'b0);
        repeat (10) cycle(NOP, 1'b0, 1'b0);
        chk("t5_level_before", 32'(level), 32'd1);
        cycle(STOP, 1'b0, 1'b0);
        chk("t5_pdm_clk_low", 32'(pdm_clk), 32'd0);
        chk("t5_level_kept",  32'(level),   32'd1);
        cycle(NOP, 1'b0, 1'b1);
        cycle(START, 1'b1, 1'b0);
        cyc = 0;
        while (!valid && cyc < 200) begin
            cycle(NOP, 1'b1, 1'b0);
            cyc++;
        end
        chk("t5_restart_word", dout, 32'h00080008);

        // Random commands, data and pops
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            c = NOP;
            if (r < 2)       c = STOP;
            else if (r < 4)  c = CLEAR;
            else if (r < 12) c = START;
            cycle(c, 1'($urandom()), 1'($urandom_range(0, 99) < ((i < 1500) ? 25 : 1)));
        end

        // 6: asynchronous reset mid-frame with three words queued
        cycle(CLEAR, 1'b0, 1'b0);
        cycle(START, 1'($urandom()), 1'b0);
        cyc = 0;
        while (level != 3 && cyc < 300) begin
            cycle(NOP, 1'($urandom()), 1'b0);
            cyc++;
        end
        chk("t6_level3", 32'(level), 32'd3);
        repeat (5) cycle(NOP, 1'($urandom()), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_pdm_clk",  32'(pdm_clk),  32'd0);
        chk("t6_dout",     dout,          32'h0);
        chk("t6_valid",    32'(valid),    32'd0);
        chk("t6_level",    32'(level),    32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_bsy",      32'(bsy),      32'd0);
        model_reset();
        ctrl = NOP; pop = 1'b0;
        @(negedge AHBclk);
        rst = 1'b1;
        repeat (4) cycle(NOP, 1'($urandom()), 1'b0);
        chk("t6_valid_after", 32'(valid), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
